// File: rtl/lsu_ctrl_pkg.sv
// rtl/lsu_ctrl_pkg.sv - shared encodings for the load/store unit
// Purpose: state, size and cause codes used by decode and lsu_ctrl, plus the
// alignment rule, so that every user applies one definition of misalignment.
// Ports: none (package).
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MISAL   = 2'b01;
  localparam logic [1:0] CAUSE_BUSERR  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  // Size code 11 has no legal encoding, so it is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = addr_lo[0];
      SZ_W:    is_misaligned = |addr_lo;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// rtl/lsu_ctrl_align.sv - byte-lane steering for stores and load extraction
// Purpose: purely combinational lane logic for lsu_ctrl.
// Ports:
//   wen        in   1  store (1) / load (0); loads get zero mask and data
//   size       in   2  SZ_B / SZ_H / SZ_W
//   in_signed  in   1  sign-extend loaded byte/half
//   addr_lo    in   2  low address bits selecting the lane
//   wdata      in  32  unshifted store data
//   rdata      in  32  bus read word
//   wmask      out  4  byte-lane write mask
//   lane_wdata out 32  store data replicated into every lane
//   ext_rdata  out 32  extracted and extended load data
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic        wen,
  input  logic [1:0]  size,
  input  logic        in_signed,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] lane_wdata,
  output logic [31:0] ext_rdata
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = rdata >> {addr_lo, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wmask      = 4'b0000;
    lane_wdata = 32'h0;
    ext_rdata  = 32'h0;
    case (size)
      SZ_B: begin
        if (wen) begin
          wmask      = 4'b0001 << addr_lo;
          lane_wdata = {4{wdata[7:0]}};
        end
        ext_rdata = {{24{in_signed & byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        if (wen) begin
          wmask      = 4'b0011 << {addr_lo[1], 1'b0};
          lane_wdata = {2{wdata[15:0]}};
        end
        ext_rdata = {{16{in_signed & half_sel[15]}}, half_sel};
      end
      SZ_W: begin
        if (wen) begin
          wmask      = 4'b1111;
          lane_wdata = wdata;
        end
        ext_rdata = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer between execute and the data bus
// Purpose: accepts one operation, issues an aligned bus request, waits for the
// response (bounded by TIMEOUT), returns extended load data or an error cause.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready/in_*          operation from execute
//   mem_req_valid/ready/addr/wen/wmask/wdata   bus request
//   mem_resp_valid/ready/rdata/err  bus response
//   out_valid/ready/rdata/err/cause result to writeback
// All outputs decode from state and captured registers only.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [1:0]  in_size,
  input  logic        in_signed,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [3:0]  mem_req_wmask,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_resp_rdata,
  input  logic        mem_resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic [1:0]  out_cause
);

  lsu_state_t  state, state_nxt;
  logic [TO_W-1:0] cnt;
  logic        r_wen, r_signed, r_err;
  logic [1:0]  r_size, r_cause;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata, al_rdata;
  logic        timeout_hit;

  assign timeout_hit = (cnt == TO_W'(TIMEOUT - 1));

  lsu_align u_align (
    .wen        (r_wen),
    .size       (r_size),
    .in_signed  (r_signed),
    .addr_lo    (r_addr[1:0]),
    .wdata      (r_wdata),
    .rdata      (mem_resp_rdata),
    .wmask      (al_wmask),
    .lane_wdata (al_wdata),
    .ext_rdata  (al_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)
                 state_nxt = is_misaligned(in_size, in_addr[1:0]) ? ST_DONE : ST_REQ;
      ST_REQ:  if (mem_req_ready) state_nxt = ST_WAIT;
      ST_WAIT: if (mem_resp_valid || timeout_hit) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready       = (state == ST_IDLE);
    mem_req_valid  = (state == ST_REQ);
    mem_req_addr   = mem_req_valid ? {r_addr[31:2], 2'b00} : 32'h0;
    mem_req_wen    = mem_req_valid & r_wen;
    mem_req_wmask  = mem_req_valid ? al_wmask : 4'b0000;
    mem_req_wdata  = mem_req_valid ? al_wdata : 32'h0;
    mem_resp_ready = (state == ST_WAIT);
    out_valid      = (state == ST_DONE);
    out_rdata      = out_valid ? r_rdata : 32'h0;
    out_err        = out_valid & r_err;
    out_cause      = out_valid ? r_cause : CAUSE_NONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      r_wen    <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
      r_cause  <= CAUSE_NONE;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          r_wen    <= in_wen;
          r_size   <= in_size;
          r_signed <= in_signed;
          r_addr   <= in_addr;
          r_wdata  <= in_wdata;
          r_rdata  <= 32'h0;
          if (is_misaligned(in_size, in_addr[1:0])) begin
            r_err   <= 1'b1;
            r_cause <= CAUSE_MISAL;
          end else begin
            r_err   <= 1'b0;
            r_cause <= CAUSE_NONE;
          end
        end
        ST_REQ: if (mem_req_ready) cnt <= '0;
        ST_WAIT: begin
          // A response in the final counted cycle beats the timeout.
          if (mem_resp_valid) begin
            if (mem_resp_err) begin
              r_err   <= 1'b1;
              r_cause <= CAUSE_BUSERR;
            end else if (!r_wen) begin
              r_rdata <= al_rdata;
            end
          end else if (timeout_hit) begin
            r_err   <= 1'b1;
            r_cause <= CAUSE_TIMEOUT;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_wen, in_signed;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata;
  logic        in_ready;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid, mem_resp_ready, mem_resp_err;
  logic [31:0] mem_resp_rdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic [1:0]  out_cause;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(TMO), .TO_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_size(in_size),
    .in_signed(in_signed), .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wmask(mem_req_wmask), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_err(out_err), .out_cause(out_cause)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " in_ready"}, in_ready, 1);
    check({tag, " req_valid"}, mem_req_valid, 0);
    check({tag, " req_addr"}, mem_req_addr, 0);
    check({tag, " req_wen"}, mem_req_wen, 0);
    check({tag, " req_wmask"}, mem_req_wmask, 0);
    check({tag, " req_wdata"}, mem_req_wdata, 0);
    check({tag, " resp_ready"}, mem_resp_ready, 0);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " out_rdata"}, out_rdata, 0);
    check({tag, " out_err"}, out_err, 0);
    check({tag, " out_cause"}, out_cause, 0);
  endtask

  // d = number of WAIT cycles that pass before the response is driven;
  // d >= TMO means the bus never answers.
  task automatic do_op(input logic wen, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int req_stall, input int d, input logic [31:0] rd,
                       input logic rerr, input int out_stall);
    logic        misal;
    logic [3:0]  emask;
    logic [31:0] ewd, erd, v;
    logic        eerr;
    logic [1:0]  ecause;
    int          bl, hl;

    bl = int'(addr % 4);
    hl = int'((addr / 2) % 2);
    misal = (size == 2'd3) || ((addr % (32'd1 << size)) != 0);
    emask = 4'h0;
    ewd   = 32'h0;
    if (wen) begin
      case (size)
        2'd0: begin emask = 4'(1 << bl);       ewd = (wd & 32'hFF)   * 32'h01010101; end
        2'd1: begin emask = 4'(3 << (2 * hl)); ewd = (wd & 32'hFFFF) * 32'h00010001; end
        default: begin emask = 4'hF; ewd = wd; end
      endcase
    end
    case (size)
      2'd0: begin v = (rd >> (8 * bl)) & 32'hFF;
              if (sgn && v >= 32'h80) v = v + 32'hFFFFFF00; end
      2'd1: begin v = (rd >> (16 * hl)) & 32'hFFFF;
              if (sgn && v >= 32'h8000) v = v + 32'hFFFF0000; end
      default: v = rd;
    endcase
    if (misal)          begin eerr = 1; ecause = 2'd1; erd = 0; end
    else if (d >= TMO)  begin eerr = 1; ecause = 2'd3; erd = 0; end
    else if (rerr)      begin eerr = 1; ecause = 2'd2; erd = 0; end
    else                begin eerr = 0; ecause = 2'd0; erd = wen ? 32'h0 : v; end

    @(negedge clk);
    check("accept in_ready", in_ready, 1);
    in_valid = 1; in_wen = wen; in_size = size; in_signed = sgn;
    in_addr = addr; in_wdata = wd;
    @(posedge clk); #1;
    in_valid = 0; in_wen = $urandom; in_size = 2'($urandom); in_signed = $urandom;
    in_addr = $urandom; in_wdata = $urandom;
    check("post-accept in_ready", in_ready, 0);

    if (!misal) begin
      for (int i = 0; i <= req_stall; i++) begin
        check("req_valid", mem_req_valid, 1);
        check("req_addr", mem_req_addr, addr & 32'hFFFFFFFC);
        check("req_wen", mem_req_wen, wen);
        check("req_wmask", mem_req_wmask, emask);
        check("req_wdata", mem_req_wdata, ewd);
        check("req resp_ready", mem_resp_ready, 0);
        mem_req_ready  = (i == req_stall);
        mem_resp_valid = $urandom;
        mem_resp_rdata = $urandom;
        mem_resp_err   = $urandom;
        @(posedge clk); #1;
      end
      mem_req_ready = 0; mem_resp_valid = 0;
      check("wait req_valid", mem_req_valid, 0);
      for (int i = 0; i < TMO; i++) begin
        check("wait resp_ready", mem_resp_ready, 1);
        check("wait out_valid", out_valid, 0);
        mem_resp_valid = (i == d);
        mem_resp_rdata = (i == d) ? rd : 32'($urandom);
        mem_resp_err   = (i == d) ? rerr : 1'($urandom);
        @(posedge clk); #1;
        mem_resp_valid = 0;
        if (i == d) break;
      end
      check("end-of-wait resp_ready", mem_resp_ready, 0);
    end else begin
      check("misal req_valid", mem_req_valid, 0);
    end

    for (int i = 0; i <= out_stall; i++) begin
      check("out_valid", out_valid, 1);
      check("out_rdata", out_rdata, erd);
      check("out_err", out_err, eerr);
      check("out_cause", out_cause, ecause);
      out_ready      = (i == out_stall);
      mem_resp_valid = $urandom;
      mem_resp_rdata = $urandom;
      @(posedge clk); #1;
    end
    out_ready = 0; mem_resp_valid = 0;
    check("post-done out_valid", out_valid, 0);
    check("post-done in_ready", in_ready, 1);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_wen = 0; in_size = 0; in_signed = 0;
    in_addr = 0; in_wdata = 0; mem_req_ready = 0; mem_resp_valid = 0;
    mem_resp_rdata = 0; mem_resp_err = 0; out_ready = 0;
    #12;
    check_idle_outputs("reset");
    @(negedge clk); rst_n = 1;

    // sw: full word, response after 2 WAIT cycles
    do_op(1, 2'd2, 0, 32'h80000004, 32'hDEADBEEF, 0, 2, 32'h12345678, 0, 0);
    // lb / lbu from the top lane
    do_op(0, 2'd0, 1, 32'h80000003, 32'h0, 0, 0, 32'h80112233, 0, 0);
    do_op(0, 2'd0, 0, 32'h80000003, 32'h0, 0, 1, 32'h80112233, 0, 1);
    // lh misaligned
    do_op(0, 2'd1, 1, 32'h80000001, 32'h0, 0, 0, 32'h0, 0, 0);
    // illegal size
    do_op(1, 2'd3, 0, 32'h80000000, 32'h55, 0, 0, 32'h0, 0, 0);
    // sh with request and writeback backpressure
    do_op(1, 2'd1, 0, 32'h80000002, 32'h0000ABCD, 5, 0, 32'h0, 0, 3);
    // timeout, response in the last allowed cycle, bus error
    do_op(0, 2'd2, 0, 32'h80000010, 32'h0, 0, 99, 32'hCAFEF00D, 0, 0);
    do_op(0, 2'd1, 1, 32'h80000012, 32'h0, 1, TMO - 1, 32'h8001FFFF, 0, 0);
    do_op(0, 2'd2, 0, 32'h80000020, 32'h0, 0, 1, 32'hFFFFFFFF, 1, 0);

    // reset during WAIT
    @(negedge clk);
    in_valid = 1; in_wen = 0; in_size = 2'd2; in_signed = 0; in_addr = 32'h80000040;
    mem_req_ready = 1;
    @(posedge clk); #1; in_valid = 0;
    @(posedge clk); #1; mem_req_ready = 0;
    check("pre-reset resp_ready", mem_resp_ready, 1);
    #2 rst_n = 0; #1;
    check_idle_outputs("mid-reset");
    @(negedge clk); rst_n = 1;
    mem_resp_valid = 1; mem_resp_rdata = 32'hA5A5A5A5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("late resp out_valid", out_valid, 0);
      check("late resp in_ready", in_ready, 1);
    end
    mem_resp_valid = 0;

    // randomized operations
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      sz = 2'($urandom_range(0, 9) < 9 ? $urandom_range(0, 2) : 3);
      a  = 32'h80000000 | ($urandom & 32'h0000FFFF);
      if ($urandom_range(0, 3) != 0)
        a = a & ~((32'd1 << sz) - 1);
      do_op(1'($urandom), sz, 1'($urandom), a, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 5), $urandom,
            $urandom_range(0, 7) == 0, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
